// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package dmem_responder_pkg;

   // Responder FSM states.
   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_e;

   localparam int unsigned DATA_W = 32;
   // Byte-enable lane count of a 32-bit word.
   localparam int unsigned BE_W   = 4;
   // Latency counter width; covers LATENCY up to 15.
   localparam int unsigned CNT_W  = 4;

   // Misaligned or beyond the last stored word.
   function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word store with per-byte write enables and registered read data.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [IDX_W-1:0]  index,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_W-1:0] rdata_q;

   // Either a lane-masked write or a read; read data holds until the next read.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) begin
                  mem_q[index][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[index];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, wait-stated access, valid/ready response out.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic ZERO_LAT = (LATENCY == 0);
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

   dmem_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wen_q, wen_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rd_ok_q, rd_ok_d;

   logic              accept;
   logic              access;
   logic              acc_wen;
   logic [31:0]       acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [BE_W-1:0]   acc_be;
   logic              acc_bad;
   logic              arr_en;
   logic [DATA_W-1:0] arr_rdata;

   assign req_ready = (state_q == DMEM_IDLE) && reset;
   assign accept    = req_valid && req_ready;

   // Pick the access fields: live request on the zero-latency path, latched copy otherwise.
   always_comb begin
      if (state_q == DMEM_IDLE) begin
         acc_wen   = req_wen;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end else begin
         acc_wen   = wen_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
      acc_bad = addr_is_bad(acc_addr, DEPTH_WORDS);
      access  = ((state_q == DMEM_IDLE) && accept && ZERO_LAT) ||
                ((state_q == DMEM_WAIT) && (cnt_q == '0) && reset);
      arr_en  = access && !acc_bad;
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (acc_wen),
      .be    (acc_be),
      .index (acc_addr[IDX_W+1:2]),
      .wdata (acc_wdata),
      .rdata (arr_rdata)
   );

   // Next-state logic for FSM, latency counter, request latch and response flags.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_err_d   = rsp_err_q;
      rd_ok_d     = rd_ok_q;

      unique case (state_q)
         DMEM_IDLE: begin
            if (accept) begin
               wen_d   = req_wen;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = CNT_INIT;
               state_d = ZERO_LAT ? DMEM_RESP : DMEM_WAIT;
            end
         end
         DMEM_WAIT: begin
            if (cnt_q == '0) begin
               state_d = DMEM_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DMEM_RESP: begin
            if (rsp_ready) begin
               state_d   = DMEM_IDLE;
               rsp_err_d = 1'b0;
               rd_ok_d   = 1'b0;
            end
         end
         default: state_d = DMEM_IDLE;
      endcase

      // Response flags are fixed on the edge that enters RESP and held until handed back.
      if (access) begin
         rsp_err_d = acc_bad;
         rd_ok_d   = !acc_bad && !acc_wen;
      end

      rsp_valid_d = (state_d == DMEM_RESP);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= DMEM_IDLE;
         cnt_q       <= '0;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_ok_q     <= rd_ok_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   // Array read data is only meaningful for a good load; stores and errors return zero.
   assign rsp_rdata = rd_ok_q ? arr_rdata : '0;

endmodule
